rect_fill_engine: RTL and testbench

- Parametrised successor to the single-box pixel drawer.
- Accepts rectangle fill commands through a valid/ready port into an internal command FIFO, clips each rectangle to the screen, and emits one pixel per clock in row-major order to the VGA adapter.
- Sits between the screen drawer(s) and the VGA adapter. Lets several producers queue background, paddle and ball boxes without stalling each other.

---
 rtl/rect_fill_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//   Queues rectangle fill commands in a small FIFO, clips each one to the
//   visible screen and streams its pixels, one per clock in row-major order,
//   to the VGA adapter.
//
// Optional build macro: RECT_OUTLINE_EN
//   When defined, each command carries an s_outline bit. Outlined rectangles
//   still take ew*eh draw cycles, but plot is only raised on border pixels.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   s_valid / s_ready     command handshake (push on s_valid && s_ready)
//   s_x, s_y, s_w, s_h    top-left corner and size of the rectangle
//   s_color               fill colour
//   s_outline             (RECT_OUTLINE_EN only) draw border pixels only
//   vga_x, vga_y, colour  current pixel, all zero when plot is low
//   plot                  pixel write strobe
//   busy                  queue non-empty or a rectangle in progress
//   fifo_count            number of queued commands
module rect_fill_engine #(
  parameter int COORD_W       = 9,
  parameter int COLOR_W       = 3,
  parameter int VGA_X_W       = 8,
  parameter int VGA_Y_W       = 7,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int FIFO_DEPTH    = 4,
  parameter int FIFO_AW       = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [COORD_W-1:0] s_w,
  input  logic [COORD_W-1:0] s_h,
  input  logic [COLOR_W-1:0] s_color,
`ifdef RECT_OUTLINE_EN
  input  logic               s_outline,
`endif
  output logic [VGA_X_W-1:0] vga_x,
  output logic [VGA_Y_W-1:0] vga_y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  typedef enum logic {IDLE, DRAW} state_t;

  localparam int EW = COORD_W + 1;  // extended width for clipping arithmetic
  localparam logic [EW-1:0]      SW_EXT = EW'(SCREEN_WIDTH);
  localparam logic [EW-1:0]      SH_EXT = EW'(SCREEN_HEIGHT);
  localparam logic [FIFO_AW:0]   DEPTH  = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [EW-1:0]      ONE_E  = EW'(1);

  // Command storage (no reset needed: validity is tracked by the count)
  logic [COORD_W-1:0] mem_x [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_y [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_w [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_h [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_c [FIFO_DEPTH];
`ifdef RECT_OUTLINE_EN
  logic               mem_o [FIFO_DEPTH];
`endif

  state_t             state_q, state_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [EW-1:0]      ew_q, ew_d, eh_q, eh_d, col_q, col_d, row_q, row_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               outline_q, outline_d;

  logic               push, pop, discard, start, col_last, row_last;
  logic [EW-1:0]      head_x, head_y, head_w, head_h, x_room, y_room;
  logic [EW-1:0]      col_inc, row_inc, px, py;

  assign s_ready    = (count_q != DEPTH);
  assign fifo_count = count_q;
  assign busy       = (state_q == DRAW) || (count_q != '0);

  assign push = s_valid && s_ready;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // Head entry zero-extended so SCREEN - x cannot wrap for x < SCREEN
  assign head_x = {1'b0, mem_x[rd_ptr_q]};
  assign head_y = {1'b0, mem_y[rd_ptr_q]};
  assign head_w = {1'b0, mem_w[rd_ptr_q]};
  assign head_h = {1'b0, mem_h[rd_ptr_q]};
  assign x_room = SW_EXT - head_x;
  assign y_room = SH_EXT - head_y;

  assign discard = (head_w == '0) || (head_h == '0) ||
                   (head_x >= SW_EXT) || (head_y >= SH_EXT);
  assign start   = pop && !discard;

  assign col_inc  = col_q + ONE_E;
  assign row_inc  = row_q + ONE_E;
  assign col_last = (col_inc == ew_q);
  assign row_last = (row_inc == eh_q);

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRAW;
      DRAW:    if (col_last && row_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers: load on start, walk columns then rows while drawing
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    ew_d      = ew_q;
    eh_d      = eh_q;
    color_d   = color_q;
    outline_d = outline_q;
    col_d     = col_q;
    row_d     = row_q;
    if (state_q == IDLE) begin
      if (start) begin
        x_d     = mem_x[rd_ptr_q];
        y_d     = mem_y[rd_ptr_q];
        ew_d    = (head_w < x_room) ? head_w : x_room;
        eh_d    = (head_h < y_room) ? head_h : y_room;
        color_d = mem_c[rd_ptr_q];
`ifdef RECT_OUTLINE_EN
        outline_d = mem_o[rd_ptr_q];
`else
        outline_d = 1'b0;
`endif
        col_d   = '0;
        row_d   = '0;
      end
    end else begin
      if (col_last) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_inc;
      end
    end
  end

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ew_q      <= '0;
      eh_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ew_q      <= ew_d;
      eh_q      <= eh_d;
      col_q     <= col_d;
      row_q     <= row_d;
      color_q   <= color_d;
      outline_q <= outline_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_x[wr_ptr_q] <= s_x;
      mem_y[wr_ptr_q] <= s_y;
      mem_w[wr_ptr_q] <= s_w;
      mem_h[wr_ptr_q] <= s_h;
      mem_c[wr_ptr_q] <= s_color;
`ifdef RECT_OUTLINE_EN
      mem_o[wr_ptr_q] <= s_outline;
`endif
    end
  end

  // Output logic: pixel address is origin plus iterators, zeroed when idle
  assign px = {1'b0, x_q} + col_q;
  assign py = {1'b0, y_q} + row_q;

  always_comb begin
    plot   = 1'b0;
    vga_x  = '0;
    vga_y  = '0;
    colour = '0;
    if (state_q == DRAW) begin
      // Interior pixels of an outlined box still consume a cycle, unplotted
      plot = !outline_q || (col_q == '0) || col_last ||
             (row_q == '0) || row_last;
      if (plot) begin
        vga_x  = VGA_X_W'(px);
        vga_y  = VGA_Y_W'(py);
        colour = color_q;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [8:0] s_x = '0, s_y = '0, s_w = '0, s_h = '0;
  logic [2:0] s_color = '0;
`ifdef RECT_OUTLINE_EN
  logic       s_outline = 1'b0;
`endif
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail = 0;
  int plot_cnt = 0;
  bit saw_full = 1'b0;
  logic [17:0] exp_q[$];

  rect_fill_engine dut (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_w(s_w), .s_h(s_h), .s_color(s_color),
`ifdef RECT_OUTLINE_EN
    .s_outline(s_outline),
`endif
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack(input int x, input int y, input int c);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    px = 8'(x);
    py = 7'(y);
    pc = 3'(c);
    return {px, py, pc};
  endfunction

  // Reference model: expected pixel list of one command, straight from the clip rules
  task automatic model(input int x, y, w, h, c, o);
    int ew, eh;
    if (w == 0 || h == 0 || x >= SW || y >= SH) return;
    ew = (w < SW - x) ? w : SW - x;
    eh = (h < SH - y) ? h : SH - y;
    for (int r = 0; r < eh; r++)
      for (int k = 0; k < ew; k++)
        if (o == 0 || r == 0 || r == eh - 1 || k == 0 || k == ew - 1)
          exp_q.push_back(pack(x + k, y + r, c));
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      chk("s_ready_vs_count", int'(s_ready), int'(fifo_count != 3'(DEPTH)));
      if (fifo_count == 3'(DEPTH)) saw_full = 1'b1;
      if (plot) begin
        plot_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d expected no pixel",
                   vga_x, vga_y, colour);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("pixel", int'({vga_x, vga_y, colour}), int'(e));
          $display("pixel (%0d,%0d) c=%0d", vga_x, vga_y, colour);
        end
      end else begin
        chk("idle_outputs_zero", int'({vga_x, vga_y, colour}), 0);
      end
    end
  end

  task automatic push(input int x, y, w, h, c, o);
    int guard = 0;
    bit rdy;
    s_valid = 1'b1;
    s_x = 9'(x); s_y = 9'(y); s_w = 9'(w); s_h = 9'(h); s_color = 3'(c);
`ifdef RECT_OUTLINE_EN
    s_outline = o[0];
`endif
    do begin
      rdy = s_ready;
      @(posedge clock); #1;
      guard++;
    end while (!rdy && guard < 2000);
    s_valid = 1'b0;
    if (!rdy) chk("push_timeout", 0, 1);
    else begin
`ifdef RECT_OUTLINE_EN
      model(x, y, w, h, c, o);
`else
      model(x, y, w, h, c, 0);
`endif
      $display("push x=%0d y=%0d w=%0d h=%0d c=%0d o=%0d", x, y, w, h, c, o);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 30000) begin
      @(posedge clock); #1;
      g++;
    end
    chk("drain_busy", int'(busy), 0);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_fifo_count", int'(fifo_count), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic 3x2 box with latency check
    push(2, 3, 3, 2, 5, 0);
    chk("lat_plot_t1", int'(plot), 0);
    @(posedge clock); #1;
    chk("lat_plot_t2", int'(plot), 1);
    chk("lat_first_x", int'(vga_x), 2);
    chk("lat_first_y", int'(vga_y), 3);
    chk("lat_first_c", int'(colour), 5);
    for (int i = 1; i < 6; i++) begin
      @(posedge clock); #1;
      chk("box_plot_run", int'(plot), 1);
    end
    @(posedge clock); #1;
    chk("box_plot_end", int'(plot), 0);
    chk("box_busy_end", int'(busy), 0);
    wait_idle();

    // Back-pressure: more 4x4 commands than the FIFO holds
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push(10 * i, 20, 4, 4, i + 1, 0);
    chk("saw_fifo_full", int'(saw_full), 1);
    wait_idle();

    // Clipping and off-screen discard
    push(158, 118, 10, 10, 6, 0);
    push(200, 5, 4, 4, 1, 0);
    wait_idle();

    // Zero width discarded, then a single pixel
    plot_cnt = 0;
    push(10, 10, 0, 5, 2, 0);
    push(20, 20, 1, 1, 7, 0);
    wait_idle();
    chk("single_pixel_count", plot_cnt, 1);

    // Reset mid-draw with commands queued
    push(0, 0, 10, 10, 3, 0);
    push(30, 30, 5, 5, 4, 0);
    push(40, 40, 5, 5, 5, 0);
    repeat (20) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    exp_q.delete();
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_fifo_count", int'(fifo_count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    reset_n = 1'b1;
    plot_cnt = 0;
    repeat (150) @(posedge clock);
    #1;
    chk("midrst_no_pixels", plot_cnt, 0);
    chk("midrst_still_idle", int'(busy), 0);

`ifdef RECT_OUTLINE_EN
    // Outlined 4x3: 12 draw cycles, 10 plotted
    plot_cnt = 0;
    push(5, 5, 4, 3, 4, 1);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("outline_busy_cycles", n, 13);
    chk("outline_plot_count", plot_cnt, 10);
    wait_idle();
`endif

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      int x, y, w, h;
      x = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 170));
      y = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 125));
      w = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) begin
        w = int'($urandom_range(100, 511));
        h = int'($urandom_range(1, 3));
      end
      push(x, y, w, h, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(posedge clock);
      #1;
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
